// File: rtl/btn_move_pulser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_move_pulser_pkg
// Purpose  : Shared button index constants, repeat-FSM state encoding and
//            the fixed-priority pick helper for the button move pulser.
// Revision : 1.0  initial release
// ============================================================================
package btn_move_pulser_pkg;

  localparam int c_BTN_UP    = 0;
  localparam int c_BTN_DOWN  = 1;
  localparam int c_BTN_LEFT  = 2;
  localparam int c_BTN_RIGHT = 3;
  localparam int c_NUM_BTN   = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_WAIT = 2'd1,
    ST_REPEAT    = 2'd2
  } btnState_t;

  // Lowest set bit wins; index 0 (up) is the highest priority.
  function automatic logic [c_NUM_BTN-1:0] pickHighest(input logic [c_NUM_BTN-1:0] req);
    return req & (~req + 4'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_move_pulser_if.sv
`default_nettype none
// ============================================================================
// Module   : btn_move_pulser_if
// Purpose  : Board-side button bundle: raw push-button inputs, one-cycle move
//            pulses and debounced levels.
// Ports    : btnUpRaw/DownRaw/LeftRaw/RightRaw  raw asynchronous buttons
//            btnUp/Down/Left/Right             one-cycle move pulses
//            btnHeld[3:0]                      debounced {right,left,down,up}
// Modports : master = board / consumer side, slave = pulser
// Revision : 1.0  initial release
// ============================================================================
interface btn_move_pulser_if;
  logic       btnUpRaw;
  logic       btnDownRaw;
  logic       btnLeftRaw;
  logic       btnRightRaw;
  logic       btnUp;
  logic       btnDown;
  logic       btnLeft;
  logic       btnRight;
  logic [3:0] btnHeld;

  modport master (
    output btnUpRaw, btnDownRaw, btnLeftRaw, btnRightRaw,
    input  btnUp, btnDown, btnLeft, btnRight, btnHeld
  );

  modport slave (
    input  btnUpRaw, btnDownRaw, btnLeftRaw, btnRightRaw,
    output btnUp, btnDown, btnLeft, btnRight, btnHeld
  );
endinterface
`default_nettype wire

// File: rtl/btn_move_pulser_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_move_pulser_debounce
// Purpose  : One button: 2-FF synchronizer followed by a debounce counter.
//            The level only flips after DEBOUNCE_CYCLES consecutive cycles
//            of the synchronized input disagreeing with it.
// Ports    : clk, rst       clock, synchronous active-high reset
//            btnRaw   in    raw asynchronous button
//            btnLevel out   debounced level
// Revision : 1.0  initial release
// ============================================================================
module btn_move_pulser_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic btnLevel
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btnRaw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
        // This edge completes DEBOUNCE_CYCLES disagreeing samples.
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign btnLevel = r_level;

endmodule
`default_nettype wire

// File: rtl/btn_move_pulser.sv
`default_nettype none
// ============================================================================
// Module   : btn_move_pulser
// Purpose  : Turns four raw push-buttons into clean, mutually exclusive
//            one-cycle move pulses with hold-to-repeat.
// Ports    : clk   in  system clock
//            rst   in  synchronous reset, active-high
//            bus   slave modport of btn_move_pulser_if (raw buttons in,
//                  registered move pulses and debounced levels out)
// Revision : 1.0  initial release
// ============================================================================
module btn_move_pulser
  import btn_move_pulser_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int CNT_W           = 24
) (
  input  logic              clk,
  input  logic              rst,
  btn_move_pulser_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [c_NUM_BTN-1:0] w_raw;
  logic [c_NUM_BTN-1:0] w_level;
  logic [c_NUM_BTN-1:0] w_setVec;
  logic [c_NUM_BTN-1:0] w_req;
  logic [c_NUM_BTN-1:0] w_grant;
  logic [c_NUM_BTN-1:0] r_pending;
  logic [c_NUM_BTN-1:0] r_pulse;

  assign w_raw = {bus.btnRightRaw, bus.btnLeftRaw, bus.btnDownRaw, bus.btnUpRaw};

  for (genvar i = 0; i < c_NUM_BTN; i++) begin : g_btn
    btnState_t        r_state;
    btnState_t        w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_set;

    btn_move_pulser_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .btnRaw   (w_raw[i]),
      .btnLevel (w_level[i])
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_stateNext;
        r_cnt   <= w_cntNext;
      end
    end

    // IDLE is only ever occupied with the level low, so seeing the level
    // high in IDLE is the press edge.
    always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_set       = 1'b0;
      if (!w_level[i]) begin
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_set       = 1'b1;
            w_stateNext = ST_HOLD_WAIT;
            w_cntNext   = '0;
          end
          ST_HOLD_WAIT: begin
            if (r_cnt == c_DELAY_LAST) begin
              // Without repeat the counter parks here (saturated).
              if (REPEAT_EN) begin
                w_set       = 1'b1;
                w_stateNext = ST_REPEAT;
                w_cntNext   = '0;
              end
            end else begin
              w_cntNext = r_cnt + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (r_cnt == c_PERIOD_LAST) begin
              w_set     = 1'b1;
              w_cntNext = '0;
            end else begin
              w_cntNext = r_cnt + CNT_W'(1);
            end
          end
          default: begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
          end
        endcase
      end
    end

    assign w_setVec[i] = w_set;
  end

  // New requests join arbitration in the cycle they are raised, which keeps
  // the press-to-pulse latency at one register after the debounced level.
  assign w_req   = r_pending | w_setVec;
  assign w_grant = pickHighest(w_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_pulse   <= '0;
    end else begin
      r_pulse   <= w_grant;
      // A grant consumes the older pending request first; a same-cycle new
      // request for that button then survives for a later grant.
      r_pending <= (r_pending & ~(w_grant & r_pending))
                 | (w_setVec  & ~(w_grant & ~r_pending));
    end
  end

  assign bus.btnUp    = r_pulse[c_BTN_UP];
  assign bus.btnDown  = r_pulse[c_BTN_DOWN];
  assign bus.btnLeft  = r_pulse[c_BTN_LEFT];
  assign bus.btnRight = r_pulse[c_BTN_RIGHT];
  assign bus.btnHeld  = w_level;

endmodule
`default_nettype wire
